// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM-stage data access over a ready-handshake bus, with timeout and load formatting.
// Optional MISALIGN_TRAP_EN adds MisalignM and traps misaligned half/word accesses without a bus request.
module mem_access_stage #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             MemWriteM,
    input  logic [1:0]       ResultSrcM,
    input  logic [2:0]       Funct3M,
    input  logic [WIDTH-1:0] AluResultM,
    input  logic [WIDTH-1:0] WriteDataM,
    output logic             MemReq,
    output logic             MemWe,
    output logic [WIDTH-1:0] MemAddr,
    output logic [WIDTH-1:0] MemWData,
    output logic [3:0]       MemBe,
    input  logic [WIDTH-1:0] MemRData,
    input  logic             MemReady,
    output logic [WIDTH-1:0] ReadDataM,
    output logic             StallM,
`ifdef MISALIGN_TRAP_EN
    output logic             MisalignM,
`endif
    output logic             BusErrM
);
    localparam int CW = $clog2(TIMEOUT) + 1;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, rd_q, rd_d, fmt;
    logic [3:0]       be_q, be_d;
    logic [2:0]       f3_q, f3_d;
    logic             we_q, we_d, err_q, err_d, acc;
    logic [7:0]       b;
    logic [15:0]      h;
`ifdef MISALIGN_TRAP_EN
    logic             mis_q, mis_d, mis;
`endif
    always_comb begin
        acc = MemWriteM | (ResultSrcM == 2'b01);
        b = 8'(MemRData >> {addr_q[1:0], 3'b000});
        h = 16'(MemRData >> {addr_q[1], 4'b0000});
        fmt = f3_q == 3'b000 ? {{(WIDTH-8){b[7]}}, b} :
              f3_q == 3'b001 ? {{(WIDTH-16){h[15]}}, h} :
              f3_q == 3'b100 ? {{(WIDTH-8){1'b0}}, b} :
              f3_q == 3'b101 ? {{(WIDTH-16){1'b0}}, h} : MemRData;
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        we_d    = we_q;
        f3_d    = f3_q;
        rd_d    = rd_q;
        err_d   = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis_d = 1'b0;
        mis   = (Funct3M[1:0] == 2'b01 && AluResultM[0]) || (Funct3M == 3'b010 && AluResultM[1:0] != 2'b00);
`endif
        case (state_q)
            IDLE: if (acc) begin
                addr_d  = AluResultM;
                we_d    = MemWriteM;
                f3_d    = Funct3M;
                cnt_d   = '0;
                wdata_d = Funct3M == 3'b000 ? {(WIDTH/8){WriteDataM[7:0]}} :
                          Funct3M == 3'b001 ? {(WIDTH/16){WriteDataM[15:0]}} : WriteDataM;
                be_d    = !MemWriteM ? 4'b1111 :
                          Funct3M == 3'b000 ? 4'b0001 << AluResultM[1:0] :
                          Funct3M == 3'b001 ? (AluResultM[1] ? 4'b1100 : 4'b0011) : 4'b1111;
                state_d = BUSY;
`ifdef MISALIGN_TRAP_EN
                if (mis) begin
                    state_d = DONE;
                    rd_d    = '0;
                    mis_d   = 1'b1;
                end
`endif
            end
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
                // ready on the final allowed cycle still completes normally
                if (MemReady) begin
                    rd_d    = fmt;
                    state_d = DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rd_d    = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
`ifdef MISALIGN_TRAP_EN
            mis_q   <= mis_d;
`endif
        end
    end
    assign MemReq    = state_q == BUSY;
    assign MemWe     = we_q;
    assign MemAddr   = {addr_q[WIDTH-1:2], 2'b00};
    assign MemWData  = wdata_q;
    assign MemBe     = be_q;
    assign ReadDataM = rd_q;
    assign BusErrM   = err_q;
    assign StallM    = (state_q == IDLE && acc) || state_q == BUSY;
`ifdef MISALIGN_TRAP_EN
    assign MisalignM = mis_q;
`endif
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: table-driven access vectors with a scoreboard queue, plus reset and idle sequences.
module tb_mem_access_stage;
    logic        CLK = 1'b0, RST_N = 1'b0, MemWriteM = 1'b0, MemReady = 1'b0;
    logic [1:0]  ResultSrcM = 2'b00;
    logic [2:0]  Funct3M = 3'b000;
    logic [31:0] AluResultM = '0, WriteDataM = '0, MemRData = '0;
    logic        MemReq, MemWe, StallM, BusErrM;
    logic [31:0] MemAddr, MemWData, ReadDataM;
    logic [3:0]  MemBe;
`ifdef MISALIGN_TRAP_EN
    logic        misalign;
`endif
    int tests = 0, fails = 0;

    mem_access_stage dut (
        .CLK(CLK), .RST_N(RST_N), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .Funct3M(Funct3M), .AluResultM(AluResultM), .WriteDataM(WriteDataM),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemBe(MemBe), .MemRData(MemRData), .MemReady(MemReady),
        .ReadDataM(ReadDataM), .StallM(StallM),
`ifdef MISALIGN_TRAP_EN
        .MisalignM(misalign),
`endif
        .BusErrM(BusErrM)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        we;
        logic [1:0]  rs;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, rdata;
        int          rdy;
        logic [3:0]  be;
        logic [31:0] ewd, eaddr, erd;
        logic        eerr;
        int          ebusy;
    } vec_t;

    vec_t vecs[15];
    vec_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v);
        vec_t e;
        int stalls = 0, busy = 0;
        @(posedge CLK); #1;
        sb.push_back(v);
        MemWriteM = v.we; ResultSrcM = v.rs; Funct3M = v.f3;
        AluResultM = v.addr; WriteDataM = v.wdata; MemRData = v.rdata; MemReady = 1'b0;
        @(negedge CLK);
        stalls += int'(StallM);
        @(posedge CLK); #1;
        while (MemReq && busy < 40) begin
            busy++;
            MemReady = (v.rdy != 0 && busy == v.rdy);
            @(negedge CLK);
            stalls += int'(StallM);
            if (busy == 1) begin
                chk("mem_addr", MemAddr, v.eaddr);
                chk("mem_be", {28'd0, MemBe}, {28'd0, v.be});
                chk("mem_we", {31'd0, MemWe}, {31'd0, v.we});
                if (v.we) chk("mem_wdata", MemWData, v.ewd);
            end
            @(posedge CLK); #1;
        end
        MemReady = 1'b0; MemWriteM = 1'b0; ResultSrcM = 2'b00;
        @(negedge CLK);
        e = sb.pop_front();
        chk("busy_cycles", busy, e.ebusy);
        chk("stall_cycles", stalls, e.ebusy + 1);
        chk("done_stall", {31'd0, StallM}, 32'd0);
        chk("read_data", ReadDataM, e.erd);
        chk("bus_err", {31'd0, BusErrM}, {31'd0, e.eerr});
        @(negedge CLK);
        chk("bus_err_pulse", {31'd0, BusErrM}, 32'd0);
        chk("read_data_hold", ReadDataM, e.erd);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 2'b00, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1, 4'b1111, 32'hDEADBEEF, 32'h100, 32'h0, 1'b0, 1};
        vecs[1]  = '{1'b0, 2'b01, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 3, 4'b1111, 32'h0, 32'h100, 32'hFFFFFF80, 1'b0, 3};
        vecs[2]  = '{1'b0, 2'b01, 3'b101, 32'h102, 32'h0, 32'h80FF1234, 1, 4'b1111, 32'h0, 32'h100, 32'h000080FF, 1'b0, 1};
        vecs[3]  = '{1'b0, 2'b01, 3'b001, 32'h102, 32'h0, 32'h80FF1234, 2, 4'b1111, 32'h0, 32'h100, 32'hFFFF80FF, 1'b0, 2};
        vecs[4]  = '{1'b1, 2'b00, 3'b000, 32'h201, 32'h000000AB, 32'h0, 1, 4'b0010, 32'hABABABAB, 32'h200, 32'h0, 1'b0, 1};
        vecs[5]  = '{1'b0, 2'b01, 3'b100, 32'h101, 32'h0, 32'h80FF1234, 1, 4'b1111, 32'h0, 32'h100, 32'h00000012, 1'b0, 1};
        vecs[6]  = '{1'b0, 2'b01, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 1, 4'b1111, 32'h0, 32'h100, 32'h00000080, 1'b0, 1};
        vecs[7]  = '{1'b1, 2'b00, 3'b001, 32'h302, 32'h0000BEEF, 32'h0, 2, 4'b1100, 32'hBEEFBEEF, 32'h300, 32'h0, 1'b0, 2};
        vecs[8]  = '{1'b1, 2'b00, 3'b001, 32'h301, 32'h00001234, 32'h0, 1, 4'b0011, 32'h12341234, 32'h300, 32'h0, 1'b0, 1};
        vecs[9]  = '{1'b0, 2'b01, 3'b010, 32'h404, 32'h0, 32'hCAFEF00D, 16, 4'b1111, 32'h0, 32'h404, 32'hCAFEF00D, 1'b0, 16};
        vecs[10] = '{1'b0, 2'b01, 3'b010, 32'h400, 32'h0, 32'hDEADBEEF, 0, 4'b1111, 32'h0, 32'h400, 32'h0, 1'b1, 16};
        vecs[11] = '{1'b1, 2'b01, 3'b010, 32'h503, 32'h11223344, 32'h0, 1, 4'b1111, 32'h11223344, 32'h500, 32'h0, 1'b0, 1};
        vecs[12] = '{1'b1, 2'b00, 3'b000, 32'h203, 32'h12345678, 32'h0, 1, 4'b1000, 32'h78787878, 32'h200, 32'h0, 1'b0, 1};
        vecs[13] = '{1'b0, 2'b01, 3'b001, 32'h100, 32'h0, 32'h12347FFF, 1, 4'b1111, 32'h0, 32'h100, 32'h00007FFF, 1'b0, 1};
        vecs[14] = '{1'b0, 2'b01, 3'b011, 32'h108, 32'h0, 32'hA5A55A5A, 2, 4'b1111, 32'h0, 32'h108, 32'hA5A55A5A, 1'b0, 2};

        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        @(negedge CLK);
        chk("rst_req", {31'd0, MemReq}, 32'd0);
        chk("rst_we", {31'd0, MemWe}, 32'd0);
        chk("rst_be", {28'd0, MemBe}, 32'd0);
        chk("rst_addr", MemAddr, 32'd0);
        chk("rst_wdata", MemWData, 32'd0);
        chk("rst_rdata", ReadDataM, 32'd0);
        chk("rst_err", {31'd0, BusErrM}, 32'd0);
        chk("rst_stall", {31'd0, StallM}, 32'd0);

        @(posedge CLK); #1;
        ResultSrcM = 2'b10;
        @(negedge CLK);
        chk("idle_nonload_stall", {31'd0, StallM}, 32'd0);
        @(negedge CLK);
        chk("idle_nonload_req", {31'd0, MemReq}, 32'd0);
        ResultSrcM = 2'b00;

        for (int i = 0; i < 15; i++) run(vecs[i]);

        @(posedge CLK); #1;
        MemWriteM = 1'b0; ResultSrcM = 2'b01; Funct3M = 3'b010; AluResultM = 32'h600; MemRData = 32'h5555AAAA;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST_N = 1'b0; ResultSrcM = 2'b00;
        @(negedge CLK);
        chk("busy2_req", {31'd0, MemReq}, 32'd1);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        @(negedge CLK);
        chk("midrst_req", {31'd0, MemReq}, 32'd0);
        chk("midrst_rdata", ReadDataM, 32'd0);
        chk("midrst_stall", {31'd0, StallM}, 32'd0);
        @(posedge CLK); #1;
        MemReady = 1'b1;
        @(posedge CLK); #1;
        MemReady = 1'b0;
        @(negedge CLK);
        chk("late_ready_req", {31'd0, MemReq}, 32'd0);
        chk("late_ready_rdata", ReadDataM, 32'd0);
        chk("late_ready_err", {31'd0, BusErrM}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
